// File: rtl/lfsr_stream_pkg.sv
// Shared definitions for the LFSR word stream: FSM encodings and the
// per-width XNOR tap table (bit p-1 of the mask set for tap position p).
package lfsr_stream_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    function automatic logic [63:0] tap_bit(input int p);
        return 64'd1 << (p - 1);
    endfunction

    // Maximal-length XNOR taps; unsupported widths return an empty mask.
    function automatic logic [63:0] tap_mask(input int num_bits);
        logic [63:0] m;
        m = '0;
        case (num_bits)
            3:  m = tap_bit(3)  | tap_bit(2);
            4:  m = tap_bit(4)  | tap_bit(3);
            5:  m = tap_bit(5)  | tap_bit(3);
            6:  m = tap_bit(6)  | tap_bit(5);
            7:  m = tap_bit(7)  | tap_bit(6);
            8:  m = tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
            9:  m = tap_bit(9)  | tap_bit(5);
            10: m = tap_bit(10) | tap_bit(7);
            11: m = tap_bit(11) | tap_bit(9);
            12: m = tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            13: m = tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
            14: m = tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
            15: m = tap_bit(15) | tap_bit(14);
            16: m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: m = tap_bit(17) | tap_bit(14);
            18: m = tap_bit(18) | tap_bit(11);
            19: m = tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            20: m = tap_bit(20) | tap_bit(17);
            21: m = tap_bit(21) | tap_bit(19);
            22: m = tap_bit(22) | tap_bit(21);
            23: m = tap_bit(23) | tap_bit(18);
            24: m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: m = tap_bit(25) | tap_bit(22);
            26: m = tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
            27: m = tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
            28: m = tap_bit(28) | tap_bit(25);
            29: m = tap_bit(29) | tap_bit(27);
            30: m = tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
            31: m = tap_bit(31) | tap_bit(28);
            32: m = tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
            64: m = tap_bit(64) | tap_bit(63) | tap_bit(61) | tap_bit(60);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci XNOR shift: shift left, feedback into bit 0 is the XNOR of
// the tapped bits.
module lfsr_step #(
    parameter int NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] cur,
    input  logic [NUM_BITS-1:0] mask,
    output logic [NUM_BITS-1:0] nxt
);

    assign nxt = {cur[NUM_BITS-2:0], ~^(cur & mask)};

endmodule

// File: rtl/lfsr_stream.sv
// Pseudo-random word stream: STEPS XNOR shifts per word, valid/ready output,
// wrap detection against a stored seed and all-ones lock-up recovery.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no word offered; enable moves to RUN and presents state
//   RUN     | word offered on o_data; advances on each accepted word
//   LOAD    | one cycle after a seed load or lock-up recovery, o_valid=0
module lfsr_stream
    import lfsr_stream_pkg::*;
#(
    parameter int                  NUM_BITS     = 32,
    parameter int                  STEPS        = 1,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = '0,
    parameter int                  CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                i_seed_dv,
    input  logic [NUM_BITS-1:0] i_seed_data,
    output logic [NUM_BITS-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_wrap,
    output logic                o_lockup,
    output logic [CNT_W-1:0]    o_count
);

    generate
        if (!((NUM_BITS >= 3 && NUM_BITS <= 32) || NUM_BITS == 64)) begin : g_bad_width
            $error("lfsr_stream: NUM_BITS must be 3..32 or 64");
        end
        if (STEPS < 1 || STEPS > NUM_BITS) begin : g_bad_steps
            $error("lfsr_stream: STEPS must be 1..NUM_BITS");
        end
        if (DEFAULT_SEED == {NUM_BITS{1'b1}}) begin : g_bad_seed
            $error("lfsr_stream: DEFAULT_SEED must not be all-ones");
        end
    endgenerate

    localparam logic [63:0]         MASK_FULL = tap_mask(NUM_BITS);
    localparam logic [NUM_BITS-1:0] MASK      = MASK_FULL[NUM_BITS-1:0];
    localparam logic [NUM_BITS-1:0] ALL_ONES  = {NUM_BITS{1'b1}};

    logic [1:0]          fsm;
    logic [NUM_BITS-1:0] state;
    logic [NUM_BITS-1:0] seed_reg;
    logic [NUM_BITS-1:0] adv;
    logic [NUM_BITS-1:0] stage [0:STEPS];
    logic                accept;
    logic                lock;

    assign stage[0] = state;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        lfsr_step #(.NUM_BITS(NUM_BITS)) u_step (
            .cur  (stage[i]),
            .mask (MASK),
            .nxt  (stage[i+1])
        );
    end

    assign adv    = stage[STEPS];
    assign accept = (fsm == ST_RUN) && o_valid && i_ready && enable;
    // All-ones is a fixed point of the XNOR feedback; only a seed can put us there.
    assign lock   = (fsm == ST_RUN) && enable && (state == ALL_ONES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= ST_IDLE;
            state    <= DEFAULT_SEED;
            seed_reg <= DEFAULT_SEED;
            o_data   <= DEFAULT_SEED;
            o_valid  <= 1'b0;
            o_wrap   <= 1'b0;
            o_lockup <= 1'b0;
            o_count  <= '0;
        end else begin
            o_wrap <= 1'b0;
            if (i_seed_dv) begin
                state    <= i_seed_data;
                seed_reg <= i_seed_data;
                o_data   <= i_seed_data;
                o_count  <= '0;
                o_lockup <= 1'b0;
                o_valid  <= 1'b0;
                fsm      <= ST_LOAD;
            end else begin
                case (fsm)
                    ST_IDLE, ST_LOAD: begin
                        if (enable) begin
                            fsm     <= ST_RUN;
                            o_valid <= 1'b1;
                            o_data  <= state;
                        end else begin
                            fsm <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (lock) begin
                            state    <= DEFAULT_SEED;
                            seed_reg <= DEFAULT_SEED;
                            o_data   <= DEFAULT_SEED;
                            o_lockup <= 1'b1;
                            o_count  <= '0;
                            o_valid  <= 1'b0;
                            fsm      <= ST_LOAD;
                        end else if (accept) begin
                            state  <= adv;
                            o_data <= adv;
                            if (adv == seed_reg) begin
                                o_wrap  <= 1'b1;
                                o_count <= '0;
                            end else begin
                                o_count <= o_count + CNT_W'(1);
                            end
                        end
                    end
                    default: fsm <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
